// File: rtl/sar_ctrl_pkg.sv
// Shared types and constants for the SAR conversion sequencer:
// FSM state encoding, default parameter values and the sample-counter width.
package sar_ctrl_pkg;

    localparam int NBITS_DEF         = 8;
    localparam int SAMPLE_CYCLES_DEF = 4;
    localparam int SCNT_W            = 4;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        SAMPLE,
        CONV,
        LATCH
    } state_t;

    // Value loaded into the sample down-counter on entry to SAMPLE; the
    // state exits when the counter reaches zero, so load cycles-1.
    function automatic logic [SCNT_W-1:0] sample_load(input int cycles);
        return SCNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/sar_conv_ctrl_if.sv
// Result bus of the SAR sequencer: one-entry valid/ready data channel.
// master = the sequencer (drives dout/dout_valid), slave = the data sink.
interface sar_conv_ctrl_if #(
    parameter int NBITS = 8
) ();
    logic [NBITS-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;

    modport master (
        output dout,
        output dout_valid,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        output dout_ready
    );
endinterface

// File: rtl/sar_ctrl_outbuf.sv
// One-entry output register for conversion results, with a sticky overrun
// flag raised when an unconsumed result is overwritten.
import sar_ctrl_pkg::*;

module sar_ctrl_outbuf #(
    parameter int NBITS = NBITS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [NBITS-1:0] wdata,
    output logic [NBITS-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun,
    input  logic             clr_overrun
);

    logic accept;
    assign accept = dout_valid && dout_ready;

    // Data register: only a new conversion changes it, so dout is stable while valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= '0;
        end else if (wr) begin
            dout <= wdata;
        end
    end

    // Valid flag: a write always leaves it set, even if the old entry is taken at that edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_valid <= 1'b0;
        end else if (wr) begin
            dout_valid <= 1'b1;
        end else if (accept) begin
            dout_valid <= 1'b0;
        end
    end

    // Sticky overrun: set by a write over an entry the sink is not taking; set beats clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (wr && dout_valid && !dout_ready) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: rtl/sar_conv_ctrl.sv
// Conversion sequencer for the SAR ADC: resets the sar_algorithm core, opens
// the sampling window, runs NBITS bit trials and hands the code to a
// one-entry output register.
// Optional macro SAR_CTRL_CNT_EN adds a 16-bit completed-conversion counter
// output conv_cnt.
import sar_ctrl_pkg::*;

module sar_conv_ctrl #(
    parameter int NBITS         = NBITS_DEF,
    parameter int SAMPLE_CYCLES = SAMPLE_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             continuous,
    input  logic [NBITS-1:0] sar_d,
    output logic             sar_rst,
    output logic             sar_en,
    output logic             sample,
    output logic             comp_en,
    output logic             busy,
    output logic             overrun,
    input  logic             clr_overrun,
`ifdef SAR_CTRL_CNT_EN
    output logic [15:0]      conv_cnt,
`endif
    sar_conv_ctrl_if.master  bus
);

    localparam int BW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [BW-1:0]     BIT_LAST = BW'(NBITS - 1);
    localparam logic [SCNT_W-1:0] SCNT_LOAD = sample_load(SAMPLE_CYCLES);

    state_t            state_reg;
    logic [SCNT_W-1:0] scnt_reg;
    logic [BW-1:0]     bcnt_reg;
    logic              latch_wr;

    // The result is captured on the edge that leaves LATCH.
    assign latch_wr = (state_reg == LATCH);

    // Sequencer FSM; control outputs are registered alongside the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            scnt_reg  <= '0;
            bcnt_reg  <= '0;
            sar_rst   <= 1'b0;
            sar_en    <= 1'b0;
            sample    <= 1'b0;
            comp_en   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start || continuous) begin
                        state_reg <= RST;
                        sar_rst   <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                RST: begin
                    state_reg <= SAMPLE;
                    sar_rst   <= 1'b0;
                    sample    <= 1'b1;
                    scnt_reg  <= SCNT_LOAD;
                end
                SAMPLE: begin
                    if (scnt_reg == '0) begin
                        state_reg <= CONV;
                        sample    <= 1'b0;
                        sar_en    <= 1'b1;
                        comp_en   <= 1'b1;
                        bcnt_reg  <= '0;
                    end else begin
                        scnt_reg <= scnt_reg - 1'b1;
                    end
                end
                CONV: begin
                    if (bcnt_reg == BIT_LAST) begin
                        state_reg <= LATCH;
                        sar_en    <= 1'b0;
                        comp_en   <= 1'b0;
                    end else begin
                        bcnt_reg <= bcnt_reg + 1'b1;
                    end
                end
                LATCH: begin
                    if (continuous) begin
                        state_reg <= RST;
                        sar_rst   <= 1'b1;
                    end else begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    sar_rst   <= 1'b0;
                    sar_en    <= 1'b0;
                    sample    <= 1'b0;
                    comp_en   <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef SAR_CTRL_CNT_EN
    logic [15:0] conv_cnt_reg;

    // Completed-conversion counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conv_cnt_reg <= 16'h0000;
        end else if (latch_wr) begin
            conv_cnt_reg <= conv_cnt_reg + 16'h0001;
        end
    end

    assign conv_cnt = conv_cnt_reg;
`endif

    sar_ctrl_outbuf #(
        .NBITS (NBITS)
    ) u_outbuf (
        .clk         (clk),
        .rst         (rst),
        .wr          (latch_wr),
        .wdata       (sar_d),
        .dout        (bus.dout),
        .dout_valid  (bus.dout_valid),
        .dout_ready  (bus.dout_ready),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

endmodule

// File: tb/tb_sar_conv_ctrl.sv
// Testbench for sar_conv_ctrl: scoreboard of expected codes and their due
// cycles, checked by an independent monitor; directed checks for waveform
// widths, continuous mode, overrun, coincident accept and async reset.
module tb_sar_conv_ctrl;
    localparam int NB  = 8;
    localparam int SC  = 4;
    localparam int LAT = 2 + SC + NB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          continuous = 1'b0;
    logic [NB-1:0] sar_d = '0;
    logic          sar_rst, sar_en, sample, comp_en, busy, overrun;
    logic          clr_overrun = 1'b0;
`ifdef SAR_CTRL_CNT_EN
    logic [15:0]   conv_cnt;
`endif

    sar_conv_ctrl_if #(.NBITS(NB)) bus ();

    sar_conv_ctrl #(.NBITS(NB), .SAMPLE_CYCLES(SC)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .continuous  (continuous),
        .sar_d       (sar_d),
        .sar_rst     (sar_rst),
        .sar_en      (sar_en),
        .sample      (sample),
        .comp_en     (comp_en),
        .busy        (busy),
        .overrun     (overrun),
        .clr_overrun (clr_overrun),
`ifdef SAR_CTRL_CNT_EN
        .conv_cnt    (conv_cnt),
`endif
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int passed = 0;

    typedef struct {
        int            due;
        logic [NB-1:0] code;
    } exp_t;
    exp_t sbq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: when a result is due, the output register must present it.
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            if (sbq[0].due == cyc) begin
                exp_t e;
                e = sbq.pop_front();
                check("sb_valid", {31'd0, bus.dout_valid}, 32'd1);
                check("sb_dout", {24'd0, bus.dout}, {24'd0, e.code});
                $display("txn cycle=%0d dout=0x%02h expected=0x%02h", cyc, bus.dout, e.code);
            end else if (sbq[0].due < cyc) begin
                exp_t e;
                e = sbq.pop_front();
                check("sb_missed", 32'(cyc), 32'(e.due));
            end
        end
    end

    // One full conversion started from IDLE; counts each control strobe's width.
    task automatic do_conv(input logic [NB-1:0] code, input bit dup_start, input bit latch_ready);
        int c;
        int n_rst = 0, n_smp = 0, n_en = 0, n_cmp = 0, n_busy = 0, guard = 0;
        bit base_ready;
        base_ready = bus.dout_ready;
        sar_d = code;
        start = 1'b1;
        c = cyc;
        sbq.push_back('{due: c + 1 + LAT, code: code});
        @(negedge clk);
        start = 1'b0;
        while (busy && guard < 40) begin
            n_rst  += int'(sar_rst);
            n_smp  += int'(sample);
            n_en   += int'(sar_en);
            n_cmp  += int'(comp_en);
            n_busy += 1;
            start = (dup_start && guard == 3);
            if (latch_ready) bus.dout_ready = (cyc == c + LAT);
            guard++;
            @(negedge clk);
        end
        start = 1'b0;
        if (latch_ready) bus.dout_ready = base_ready;
        check("conv_done", {31'd0, busy}, 32'd0);
        check("sar_rst_w", 32'(n_rst), 32'd1);
        check("sample_w", 32'(n_smp), 32'(SC));
        check("sar_en_w", 32'(n_en), 32'(NB));
        check("comp_en_w", 32'(n_cmp), 32'(NB));
        check("busy_w", 32'(n_busy), 32'(LAT));
    endtask

    initial begin
        int c;
        bus.dout_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ctrl", {28'd0, sar_rst, sar_en, sample, comp_en}, 32'd0);
        check("rst_valid", {31'd0, bus.dout_valid}, 32'd0);
        check("rst_dout", {24'd0, bus.dout}, 32'd0);
        check("rst_ovr", {31'd0, overrun}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_hold", {31'd0, busy}, 32'd0);

        // Basic conversion
        do_conv(8'hA5, 1'b0, 1'b0);
        @(negedge clk);
        check("basic_idle", {31'd0, busy}, 32'd0);

        // Randomized conversions, some with a start during busy
        for (int i = 0; i < 6; i++) begin
            do_conv(8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        check("dup_ignored", {31'd0, busy}, 32'd0);

        // Continuous: two back-to-back results, RST follows LATCH directly
        @(negedge clk);
        sar_d = 8'h01;
        continuous = 1'b1;
        c = cyc;
        sbq.push_back('{due: c + 1 + LAT, code: 8'h01});
        sbq.push_back('{due: c + 1 + 2 * LAT, code: 8'h02});
        while (cyc < c + 1 + LAT) @(negedge clk);
        check("cont_busy", {31'd0, busy}, 32'd1);
        check("cont_rst", {31'd0, sar_rst}, 32'd1);
        sar_d = 8'h02;
        repeat (5) @(negedge clk);
        continuous = 1'b0;
        while (cyc < c + 2 + 2 * LAT) @(negedge clk);
        check("cont_stop", {31'd0, busy}, 32'd0);

        // Overrun: two results with the sink stalled
        bus.dout_ready = 1'b0;
        do_conv(8'h3C, 1'b0, 1'b0);
        check("ovr_none", {31'd0, overrun}, 32'd0);
        do_conv(8'hC3, 1'b0, 1'b0);
        check("ovr_set", {31'd0, overrun}, 32'd1);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        check("ovr_clr", {31'd0, overrun}, 32'd0);
        check("ovr_keep", {24'd0, bus.dout}, 32'hC3);
        bus.dout_ready = 1'b1;
        @(negedge clk);
        bus.dout_ready = 1'b0;
        check("accept_clr", {31'd0, bus.dout_valid}, 32'd0);

        // Sink accepts on the very LATCH cycle that writes a new code
        do_conv(8'h5A, 1'b0, 1'b0);
        do_conv(8'h96, 1'b0, 1'b1);
        check("coinc_ovr", {31'd0, overrun}, 32'd0);
        @(negedge clk);
        check("coinc_valid", {31'd0, bus.dout_valid}, 32'd1);
        check("coinc_dout", {24'd0, bus.dout}, 32'h96);

        // Asynchronous reset in CONV bit 4
        sar_d = 8'h77;
        start = 1'b1;
        c = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc < c + 10) @(negedge clk);
        check("mid_conv_en", {31'd0, sar_en}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("arst_ctrl", {27'd0, sar_rst, sar_en, sample, comp_en, busy}, 32'd0);
        check("arst_valid", {31'd0, bus.dout_valid}, 32'd0);
        check("arst_dout", {24'd0, bus.dout}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("arst_idle", {31'd0, busy}, 32'd0);
        check("arst_novalid", {31'd0, bus.dout_valid}, 32'd0);
        bus.dout_ready = 1'b1;
        do_conv(8'hE1, 1'b1, 1'b0);

`ifdef SAR_CTRL_CNT_EN
        force dut.conv_cnt_reg = 16'hFFFF;
        @(negedge clk);
        release dut.conv_cnt_reg;
        do_conv(8'h0F, 1'b0, 1'b0);
        check("cnt_wrap", {16'd0, conv_cnt}, 32'd0);
`endif

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end
endmodule
